// File: rtl/bubble_sort_core.sv
// bubble_sort_core
// Register-array bubble sorter. Holds K_NUMBERS unsigned N_BITS-wide words and sorts
// them ascending by repeated adjacent compare/swap passes, one compare per cycle.
// A downstream interrupt/done stage watches run_o and swap_o: run_o is high for each
// pass (PASS + END), and swap_o tells whether that pass swapped anything. A one-cycle
// GAP separates passes, so swap_o is valid on the falling edge of run_o.
//
// Ports
//   clk        in   1        clock, rising edge
//   rst_n      in   1        asynchronous active-low reset
//   wr_en_i    in   1        write strobe, honoured only while idle
//   wr_addr_i  in   A_WIDTH  write index
//   wr_data_i  in   N_BITS   write data
//   start_i    in   1        start a sort, honoured only while idle
//   rd_addr_i  in   A_WIDTH  read index
//   rd_data_o  out  N_BITS   mem[rd_addr_i], registered, one cycle latency
//   run_o      out  1        high while a pass is in progress
//   swap_o     out  1        sticky: the current/last pass swapped a pair
//   busy_o     out  1        high from start accept until back in idle
module bubble_sort_core #(
  parameter int N_BITS    = 8,
  parameter int K_NUMBERS = 8,
  parameter int A_WIDTH   = $clog2(K_NUMBERS)
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               wr_en_i,
  input  logic [A_WIDTH-1:0] wr_addr_i,
  input  logic [N_BITS-1:0]  wr_data_i,
  input  logic               start_i,
  input  logic [A_WIDTH-1:0] rd_addr_i,
  output logic [N_BITS-1:0]  rd_data_o,
  output logic               run_o,
  output logic               swap_o,
  output logic               busy_o
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_PASS,
    S_END,
    S_GAP
  } state_t;

  // Index of the last compared pair (mem[K-2] vs mem[K-1]).
  localparam logic [A_WIDTH-1:0] LAST_IDX = A_WIDTH'(K_NUMBERS - 2);

  state_t             r_state;
  state_t             w_next;
  logic [N_BITS-1:0]  r_mem [K_NUMBERS];
  logic [A_WIDTH-1:0] r_idx;
  logic               r_flag;
  logic               r_run;
  logic               r_busy;
  logic [N_BITS-1:0]  r_rdData;

  logic [A_WIDTH-1:0] w_idxNext;
  logic [N_BITS-1:0]  w_lo;
  logic [N_BITS-1:0]  w_hi;
  logic               w_swap;
  logic               w_last;

  assign w_idxNext = r_idx + A_WIDTH'(1);
  assign w_lo      = r_mem[r_idx];
  assign w_hi      = r_mem[w_idxNext];
  // Strictly greater: equal words stay put, which keeps the sort stable.
  assign w_swap    = (w_lo > w_hi);
  assign w_last    = (r_idx == LAST_IDX);

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:  if (start_i) w_next = S_PASS;
      S_PASS:  if (w_last) w_next = S_END;
      // A pass without any swap means the array is sorted.
      S_END:   w_next = r_flag ? S_GAP : S_IDLE;
      S_GAP:   w_next = S_PASS;
      default: w_next = S_IDLE;
    endcase
  end

  // run/busy are registered from the next state so they line up exactly with
  // the state they describe without a combinational decode on the outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
      r_run   <= 1'b0;
      r_busy  <= 1'b0;
    end else begin
      r_state <= w_next;
      r_run   <= (w_next == S_PASS) || (w_next == S_END);
      r_busy  <= (w_next != S_IDLE);
    end
  end

  // Storage, pass index and swap flag. The flag is cleared only on entry to
  // PASS, so it stays visible through END, GAP and IDLE.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < K_NUMBERS; i++) begin
        r_mem[i] <= '0;
      end
      r_idx    <= '0;
      r_flag   <= 1'b0;
      r_rdData <= '0;
    end else begin
      r_rdData <= r_mem[rd_addr_i];
      case (r_state)
        S_IDLE: begin
          if (wr_en_i) begin
            r_mem[wr_addr_i] <= wr_data_i;
          end
          if (start_i) begin
            r_idx  <= '0;
            r_flag <= 1'b0;
          end
        end
        S_PASS: begin
          if (w_swap) begin
            r_mem[r_idx]     <= w_hi;
            r_mem[w_idxNext] <= w_lo;
            r_flag           <= 1'b1;
          end
          if (!w_last) begin
            r_idx <= w_idxNext;
          end
        end
        S_GAP: begin
          r_idx  <= '0;
          r_flag <= 1'b0;
        end
        default: begin
        end
      endcase
    end
  end

  assign rd_data_o = r_rdData;
  assign run_o     = r_run;
  assign swap_o    = r_flag;
  assign busy_o    = r_busy;

endmodule

// File: tb/tb_bubble_sort_core.sv
// tb_bubble_sort_core
// Directed and random checks of bubble_sort_core with K_NUMBERS=4, N_BITS=8.
// Expected sorted words and per-pass swap flags come from a reference bubble sort
// in the bench and are queued when a sort is started, then consumed as the DUT
// runs its passes and as the result is read back. A small downstream model counts
// "done" events (run_o falling with swap_o low).
module tb_bubble_sort_core;

  localparam int K  = 4;
  localparam int NB = 8;
  localparam int AW = 2;

  typedef logic [NB-1:0] arr_t [K];

  logic          clk = 1'b0;
  logic          rst_n;
  logic          wr_en_i;
  logic [AW-1:0] wr_addr_i;
  logic [NB-1:0] wr_data_i;
  logic          start_i;
  logic [AW-1:0] rd_addr_i;
  logic [NB-1:0] rd_data_o;
  logic          run_o;
  logic          swap_o;
  logic          busy_o;

  int checks   = 0;
  int failures = 0;

  logic [NB-1:0] dataQ [$];
  bit            swapQ [$];

  int   doneCount = 0;
  logic prevRun   = 1'b0;

  bubble_sort_core #(
    .N_BITS   (NB),
    .K_NUMBERS(K)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .wr_en_i  (wr_en_i),
    .wr_addr_i(wr_addr_i),
    .wr_data_i(wr_data_i),
    .start_i  (start_i),
    .rd_addr_i(rd_addr_i),
    .rd_data_o(rd_data_o),
    .run_o    (run_o),
    .swap_o   (swap_o),
    .busy_o   (busy_o)
  );

  always #5 clk = ~clk;

  // Downstream done generator: a pass that ends with no swap means sorted.
  always @(negedge clk) begin
    if (prevRun && !run_o && !swap_o) doneCount <= doneCount + 1;
    prevRun <= run_o;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("[TB] FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // Loads d (last word written in the same cycle as start), and queues the
  // reference result and per-pass swap flags.
  task automatic applyStimulus(input arr_t d);
    arr_t m;
    bit   sw;
    m = d;
    do begin
      sw = 1'b0;
      for (int i = 0; i < K - 1; i++) begin
        if (m[i] > m[i+1]) begin
          logic [NB-1:0] t;
          t = m[i]; m[i] = m[i+1]; m[i+1] = t;
          sw = 1'b1;
        end
      end
      swapQ.push_back(sw);
    end while (sw);
    for (int i = 0; i < K; i++) dataQ.push_back(m[i]);
    for (int i = 0; i < K; i++) begin
      wr_en_i   = 1'b1;
      wr_addr_i = AW'(i);
      wr_data_i = d[i];
      start_i   = (i == K - 1);
      tick();
    end
    wr_en_i = 1'b0;
    start_i = 1'b0;
    $display("[TB] sort started on {%0d,%0d,%0d,%0d}, %0d passes expected",
             d[0], d[1], d[2], d[3], swapQ.size());
  endtask

  // Follows the expected pass structure cycle by cycle from the first PASS cycle.
  task automatic watchSort(input bit disturb, input int expBusy);
    int nPass;
    int busyCount;
    int runCount;
    bit expSw;
    nPass     = swapQ.size();
    busyCount = 0;
    for (int p = 0; p < nPass; p++) begin
      expSw    = swapQ.pop_front();
      runCount = 0;
      for (int c = 0; c < K; c++) begin
        if (run_o === 1'b1) runCount++;
        if (busy_o === 1'b1) busyCount++;
        if (c == K - 1) checkOutput($sformatf("swapEnd_p%0d", p + 1), swap_o, expSw);
        if (disturb && p == 0) begin
          if (c == 0) begin
            wr_en_i = 1'b1; wr_addr_i = '0; wr_data_i = 8'hFF; start_i = 1'b1;
          end
          if (c == K - 2) begin
            wr_en_i = 1'b0; start_i = 1'b0;
          end
        end
        tick();
      end
      checkOutput($sformatf("runLen_p%0d", p + 1), runCount, K);
      if (p < nPass - 1) begin
        checkOutput("gapRun", run_o, 1'b0);
        checkOutput("gapSwap", swap_o, 1'b1);
        if (busy_o === 1'b1) busyCount++;
        tick();
      end
    end
    checkOutput("idleBusy", busy_o, 1'b0);
    checkOutput("idleRun", run_o, 1'b0);
    checkOutput("idleSwap", swap_o, 1'b0);
    checkOutput("busyCycles", busyCount, expBusy);
  endtask

  task automatic readBack();
    logic [NB-1:0] exp;
    for (int i = 0; i < K; i++) begin
      rd_addr_i = AW'(i);
      tick();
      exp = (dataQ.size() > 0) ? dataQ.pop_front() : '0;
      checkOutput($sformatf("rd%0d", i), rd_data_o, exp);
    end
  endtask

  initial begin
    int doneStart;
    int expDone;
    int n;
    arr_t r;

    rst_n = 1'b0; wr_en_i = 1'b0; wr_addr_i = '0; wr_data_i = '0;
    start_i = 1'b0; rd_addr_i = '0;
    tick(); tick();
    checkOutput("rstRun", run_o, 1'b0);
    checkOutput("rstSwap", swap_o, 1'b0);
    checkOutput("rstBusy", busy_o, 1'b0);
    checkOutput("rstRd", rd_data_o, 8'd0);
    @(negedge clk);
    rst_n = 1'b1;
    tick();

    // Reverse order: worst case, 4 passes, 19 busy cycles.
    applyStimulus('{8'd3, 8'd2, 8'd1, 8'd0});
    watchSort(1'b0, 19);
    readBack();

    // Already sorted: single clean pass.
    applyStimulus('{8'd0, 8'd1, 8'd2, 8'd3});
    watchSort(1'b0, 4);
    readBack();

    // All equal: never swapped.
    applyStimulus('{8'd7, 8'd7, 8'd7, 8'd7});
    watchSort(1'b0, 4);
    readBack();

    // Only the last pair out of order.
    applyStimulus('{8'd1, 8'd2, 8'd4, 8'd3});
    watchSort(1'b0, 9);
    readBack();

    // Writes and start during a sort are ignored.
    applyStimulus('{8'd5, 8'd3, 8'd9, 8'd1});
    watchSort(1'b1, 19);
    readBack();

    // Reset in the second cycle of pass 2.
    applyStimulus('{8'd3, 8'd2, 8'd1, 8'd0});
    for (int c = 0; c < K; c++) tick();
    tick();
    tick();
    #2;
    rst_n = 1'b0;
    #1;
    checkOutput("abortRun", run_o, 1'b0);
    checkOutput("abortSwap", swap_o, 1'b0);
    checkOutput("abortBusy", busy_o, 1'b0);
    swapQ.delete();
    dataQ.delete();
    tick();
    @(negedge clk);
    rst_n = 1'b1;
    tick();
    for (int i = 0; i < K; i++) dataQ.push_back('0);
    readBack();

    applyStimulus('{8'd9, 8'd4, 8'd200, 8'd4});
    watchSort(1'b0, 14);
    readBack();

    // Random sorts with the done generator attached.
    doneStart = doneCount;
    expDone   = 0;
    for (int s = 0; s < 30; s++) begin
      for (int j = 0; j < K; j++) r[j] = NB'($urandom_range(0, 255));
      applyStimulus(r);
      n = swapQ.size();
      foreach (swapQ[q]) if (!swapQ[q]) expDone++;
      watchSort(1'b0, n * (K + 1) - 1);
      readBack();
    end
    tick();
    checkOutput("doneCount", doneCount - doneStart, expDone);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
